// File: rtl/bcd_scan_counter_if.sv
// Interface bundle for bcd_scan_counter: count controls and load data in,
// scan position, segment bus, digit commons and wrap flag out.
interface bcd_scan_counter_if #(
  parameter int unsigned DIGITS = 8
) ();
  localparam int unsigned SELW = $clog2(DIGITS);

  logic                  EN;
  logic                  UP;
  logic                  CLR;
  logic                  LOAD;
  logic [4*DIGITS-1:0]   LD_DATA;
  logic                  LZB;
  logic [SELW-1:0]       SEL;
  logic [6:0]            SEG7;
  logic [DIGITS-1:0]     SEG_COM;
  logic                  WRAP;

  // Controller side: drives the counter controls, watches the display lines.
  modport master (
    output EN, UP, CLR, LOAD, LD_DATA, LZB,
    input  SEL, SEG7, SEG_COM, WRAP
  );

  // Counter side.
  modport slave (
    input  EN, UP, CLR, LOAD, LD_DATA, LZB,
    output SEL, SEG7, SEG_COM, WRAP
  );
endinterface

// File: rtl/bcd_scan_counter.sv
// Multi-digit BCD up/down counter with a time-multiplexed 7-segment scan
// driver. Count rate and scan rate come from independent prescalers. All state
// changes on the falling edge of C; R clears everything asynchronously.
module bcd_scan_counter #(
  parameter int unsigned DIGITS   = 8,
  parameter int unsigned PRESCALE = 1,
  parameter int unsigned SCAN_DIV = 1
) (
  input logic               C,
  input logic               R,
  bcd_scan_counter_if.slave bus
);
  localparam int unsigned SELW = $clog2(DIGITS);
  // Prescaler widths never collapse to zero when the divisor is 1.
  localparam int unsigned PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned SW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [PW-1:0]   PRE_LAST  = PW'(PRESCALE - 1);
  localparam logic [SW-1:0]   SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [SELW-1:0] SEL_LAST  = SELW'(DIGITS - 1);

  // State
  logic [4*DIGITS-1:0] r_digits;
  logic [PW-1:0]       r_pre;
  logic [SW-1:0]       r_scan;
  logic [SELW-1:0]     r_sel;
  logic                r_wrap;

  // Next-state and decode nets
  logic [4*DIGITS-1:0] w_load_val;
  logic [4*DIGITS-1:0] w_step_val;
  logic                w_carry_out;
  logic [4*DIGITS-1:0] w_digits_nxt;
  logic [PW-1:0]       w_pre_nxt;
  logic                w_wrap_nxt;
  logic [SW-1:0]       w_scan_nxt;
  logic [SELW-1:0]     w_sel_nxt;
  logic [DIGITS-1:0]   w_hi_zero;
  logic [3:0]          w_cur;
  logic                w_blank;
  logic [6:0]          w_seg;
  logic [DIGITS-1:0]   w_com;

  // Load value with out-of-range nibbles clamped to 9.
  always_comb begin
    w_load_val = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bus.LD_DATA[4*i +: 4] > 4'd9) begin
        w_load_val[4*i +: 4] = 4'd9;
      end else begin
        w_load_val[4*i +: 4] = bus.LD_DATA[4*i +: 4];
      end
    end
  end

  // Ripple one BCD step through the digits; carry/borrow out of the top digit
  // means the whole counter wrapped.
  always_comb begin
    logic carry;
    w_step_val = r_digits;
    carry      = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (bus.UP) begin
          if (r_digits[4*i +: 4] == 4'd9) begin
            w_step_val[4*i +: 4] = 4'd0;
          end else begin
            w_step_val[4*i +: 4] = r_digits[4*i +: 4] + 4'd1;
            carry                = 1'b0;
          end
        end else begin
          if (r_digits[4*i +: 4] == 4'd0) begin
            w_step_val[4*i +: 4] = 4'd9;
          end else begin
            w_step_val[4*i +: 4] = r_digits[4*i +: 4] - 4'd1;
            carry                = 1'b0;
          end
        end
      end
    end
    w_carry_out = carry;
  end

  // Count path next state: CLR beats LOAD beats a prescaled step.
  always_comb begin
    w_digits_nxt = r_digits;
    w_pre_nxt    = r_pre;
    w_wrap_nxt   = 1'b0;
    if (bus.CLR) begin
      w_digits_nxt = '0;
      w_pre_nxt    = '0;
    end else if (bus.LOAD) begin
      w_digits_nxt = w_load_val;
      w_pre_nxt    = '0;
    end else if (bus.EN) begin
      if (r_pre == PRE_LAST) begin
        w_pre_nxt    = '0;
        w_digits_nxt = w_step_val;
        w_wrap_nxt   = w_carry_out;
      end else begin
        w_pre_nxt = r_pre + PW'(1);
      end
    end
  end

  // Scan path next state: free-running, ignores all count controls.
  always_comb begin
    w_scan_nxt = r_scan + SW'(1);
    w_sel_nxt  = r_sel;
    if (r_scan == SCAN_LAST) begin
      w_scan_nxt = '0;
      w_sel_nxt  = (r_sel == SEL_LAST) ? '0 : r_sel + SELW'(1);
    end
  end

  // All state registers, falling-edge clocked with asynchronous clear.
  always_ff @(negedge C or posedge R) begin
    if (R) begin
      r_digits <= '0;
      r_pre    <= '0;
      r_scan   <= '0;
      r_sel    <= '0;
      r_wrap   <= 1'b0;
    end else begin
      r_digits <= w_digits_nxt;
      r_pre    <= w_pre_nxt;
      r_scan   <= w_scan_nxt;
      r_sel    <= w_sel_nxt;
      r_wrap   <= w_wrap_nxt;
    end
  end

  // w_hi_zero[i] is set when digit i and every digit above it are zero.
  always_comb begin
    logic z;
    z         = 1'b1;
    w_hi_zero = '0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      z            = z & (r_digits[4*i +: 4] == 4'd0);
      w_hi_zero[i] = z;
    end
  end

  // Select the scanned digit and decide whether it is a blanked leading zero.
  always_comb begin
    w_cur   = r_digits[4*r_sel +: 4];
    w_blank = bus.LZB && (r_sel != '0) && w_hi_zero[r_sel];
  end

  // Seven-segment decode, bit 6 = segment a; non-BCD codes stay dark.
  always_comb begin
    unique case (w_cur)
      4'd0:    w_seg = 7'b1111110;
      4'd1:    w_seg = 7'b0110000;
      4'd2:    w_seg = 7'b1101101;
      4'd3:    w_seg = 7'b1111001;
      4'd4:    w_seg = 7'b0110011;
      4'd5:    w_seg = 7'b1011011;
      4'd6:    w_seg = 7'b1011111;
      4'd7:    w_seg = 7'b1110000;
      4'd8:    w_seg = 7'b1111111;
      4'd9:    w_seg = 7'b1110011;
      default: w_seg = 7'b0000000;
    endcase
  end

  // Active-low one-cold common for the scanned digit.
  always_comb begin
    w_com        = '1;
    w_com[r_sel] = 1'b0;
  end

  assign bus.SEL     = r_sel;
  assign bus.SEG7    = w_blank ? 7'b0000000 : w_seg;
  assign bus.SEG_COM = w_com;
  assign bus.WRAP    = r_wrap;
endmodule

// File: tb/tb_bcd_scan_counter.sv
// Scoreboard bench for bcd_scan_counter. Two 4-digit instances:
//   u_a: PRESCALE=1, SCAN_DIV=2 (wrap, scan, blanking, async reset)
//   u_b: PRESCALE=3, SCAN_DIV=1 (prescaler phase, load clamp, clear priority)
// Stimulus pushes the hand-computed expected display state for the next
// falling edge; a monitor pops and compares just after that edge.
module tb_bcd_scan_counter;
  logic C = 1'b0;
  logic R = 1'b1;
  always #5 C = ~C;

  bcd_scan_counter_if #(.DIGITS(4)) if_a ();
  bcd_scan_counter_if #(.DIGITS(4)) if_b ();

  bcd_scan_counter #(.DIGITS(4), .PRESCALE(1), .SCAN_DIV(2)) u_a (.C(C), .R(R), .bus(if_a));
  bcd_scan_counter #(.DIGITS(4), .PRESCALE(3), .SCAN_DIV(1)) u_b (.C(C), .R(R), .bus(if_b));

  typedef struct {
    string       nm;
    int unsigned sel;
    logic [6:0]  seg;
    logic        wrap;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  int n_chk = 0;
  int n_err = 0;

  // Falling edges since reset was last seen high; gives the expected scan slot.
  int unsigned edge_cnt = 0;
  always @(negedge C) edge_cnt <= R ? 0 : edge_cnt + 1;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1111110;
      4'd1:    return 7'b0110000;
      4'd2:    return 7'b1101101;
      4'd3:    return 7'b1111001;
      4'd4:    return 7'b0110011;
      4'd5:    return 7'b1011011;
      4'd6:    return 7'b1011111;
      4'd7:    return 7'b1110000;
      4'd8:    return 7'b1111111;
      4'd9:    return 7'b1110011;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic logic [6:0] seg_for(input logic [15:0] v, input int unsigned sel,
                                         input logic lzb);
    logic [15:0] hi;
    hi = v >> (4 * sel);
    if (lzb && sel != 0 && hi == 16'h0) return 7'b0000000;
    return seg_of(hi[3:0]);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_disp(input string nm, input logic [1:0] sel, input logic [6:0] seg,
                          input logic [3:0] com, input logic wrap, input exp_t e);
    logic [3:0] ecom;
    ecom = ~(4'b0001 << e.sel);
    chk({nm, " sel"}, 32'(sel), 32'(e.sel));
    chk({nm, " seg7"}, 32'(seg), 32'(e.seg));
    chk({nm, " com"}, 32'(com), 32'(ecom));
    chk({nm, " wrap"}, 32'(wrap), 32'(e.wrap));
  endtask

  // Monitor: compare whatever the stimulus promised for this edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge C);
      #1;
      if (q_a.size() != 0) begin
        e = q_a.pop_front();
        chk_disp({"A ", e.nm}, if_a.SEL, if_a.SEG7, if_a.SEG_COM, if_a.WRAP, e);
      end
      if (q_b.size() != 0) begin
        e = q_b.pop_front();
        chk_disp({"B ", e.nm}, if_b.SEL, if_b.SEG7, if_b.SEG_COM, if_b.WRAP, e);
      end
    end
  end

  task automatic cyc_a(input logic en, input logic up, input logic clr, input logic load,
                       input logic lzb, input logic [15:0] ld, input logic [15:0] val,
                       input logic wr, input string nm);
    exp_t e;
    @(posedge C);
    if_a.EN = en; if_a.UP = up; if_a.CLR = clr; if_a.LOAD = load;
    if_a.LZB = lzb; if_a.LD_DATA = ld;
    e.nm   = nm;
    e.sel  = ((edge_cnt + 1) / 2) % 4;
    e.seg  = seg_for(val, e.sel, lzb);
    e.wrap = wr;
    q_a.push_back(e);
  endtask

  task automatic cyc_b(input logic en, input logic up, input logic clr, input logic load,
                       input logic [15:0] ld, input logic [15:0] val, input logic wr,
                       input string nm);
    exp_t e;
    @(posedge C);
    if_b.EN = en; if_b.UP = up; if_b.CLR = clr; if_b.LOAD = load;
    if_b.LZB = 1'b0; if_b.LD_DATA = ld;
    e.nm   = nm;
    e.sel  = (edge_cnt + 1) % 4;
    e.seg  = seg_for(val, e.sel, 1'b0);
    e.wrap = wr;
    q_b.push_back(e);
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, " A sel"}, 32'(if_a.SEL), 32'd0);
    chk({nm, " A com"}, 32'(if_a.SEG_COM), 32'b1110);
    chk({nm, " A seg7"}, 32'(if_a.SEG7), 32'b1111110);
    chk({nm, " A wrap"}, 32'(if_a.WRAP), 32'd0);
    chk({nm, " B sel"}, 32'(if_b.SEL), 32'd0);
    chk({nm, " B com"}, 32'(if_b.SEG_COM), 32'b1110);
    chk({nm, " B seg7"}, 32'(if_b.SEG7), 32'b1111110);
    chk({nm, " B wrap"}, 32'(if_b.WRAP), 32'd0);
  endtask

  initial begin
    {if_a.EN, if_a.UP, if_a.CLR, if_a.LOAD, if_a.LZB} = '0;
    {if_b.EN, if_b.UP, if_b.CLR, if_b.LOAD, if_b.LZB} = '0;
    if_a.LD_DATA = '0;
    if_b.LD_DATA = '0;

    // Reset state
    @(posedge C);
    @(posedge C);
    #1;
    chk_reset("reset");
    R = 1'b0;

    // Up wrap on A
    cyc_a(0, 1, 0, 1, 0, 16'h9998, 16'h9998, 0, "load9998");
    cyc_a(1, 1, 0, 0, 0, 16'h0000, 16'h9999, 0, "up9999");
    cyc_a(1, 1, 0, 0, 0, 16'h0000, 16'h0000, 1, "upwrap");
    cyc_a(1, 1, 0, 0, 0, 16'h0000, 16'h0001, 0, "up0001");
    cyc_a(0, 1, 0, 0, 0, 16'h0000, 16'h0001, 0, "hold0001");

    // Down wrap on A
    cyc_a(0, 0, 1, 0, 0, 16'h0000, 16'h0000, 0, "clr");
    cyc_a(1, 0, 0, 0, 0, 16'h0000, 16'h9999, 1, "dnwrap");
    cyc_a(1, 0, 0, 0, 0, 16'h0000, 16'h9998, 0, "dn9998");
    cyc_a(1, 0, 0, 0, 0, 16'h0000, 16'h9997, 0, "dn9997");

    // Scan of 1234 across all positions
    cyc_a(0, 1, 0, 1, 0, 16'h1234, 16'h1234, 0, "load1234");
    for (int i = 0; i < 9; i++) cyc_a(0, 1, 0, 0, 0, 16'h0000, 16'h1234, 0, "scan1234");

    // Blanking of 0040
    cyc_a(0, 1, 0, 1, 1, 16'h0040, 16'h0040, 0, "load0040");
    for (int i = 0; i < 8; i++) cyc_a(0, 1, 0, 0, 1, 16'h0000, 16'h0040, 0, "lzb1");
    for (int i = 0; i < 8; i++) cyc_a(0, 1, 0, 0, 0, 16'h0000, 16'h0040, 0, "lzb0");

    // Prescale on B: step every 3 enabled edges, phase held through EN=0
    cyc_b(0, 1, 0, 1, 16'h0100, 16'h0100, 0, "load0100");
    cyc_b(1, 1, 0, 0, 16'h0000, 16'h0100, 0, "pre1");
    cyc_b(1, 1, 0, 0, 16'h0000, 16'h0100, 0, "pre2");
    cyc_b(1, 1, 0, 0, 16'h0000, 16'h0101, 0, "step0101");
    cyc_b(1, 1, 0, 0, 16'h0000, 16'h0101, 0, "pre1b");
    for (int i = 0; i < 5; i++) cyc_b(0, 1, 0, 0, 16'h0000, 16'h0101, 0, "enlow");
    cyc_b(1, 1, 0, 0, 16'h0000, 16'h0101, 0, "pre2b");
    cyc_b(1, 1, 0, 0, 16'h0000, 16'h0102, 0, "step0102");
    cyc_b(0, 1, 0, 1, 16'hA5F2, 16'h9592, 0, "clamp");
    cyc_b(0, 1, 0, 0, 16'h0000, 16'h9592, 0, "clamp2");
    cyc_b(0, 1, 0, 0, 16'h0000, 16'h9592, 0, "clamp3");
    cyc_b(0, 1, 0, 0, 16'h0000, 16'h9592, 0, "clamp4");
    cyc_b(0, 1, 1, 1, 16'h1234, 16'h0000, 0, "clrload");
    cyc_b(1, 0, 0, 0, 16'h0000, 16'h0000, 0, "dnpre1");
    cyc_b(1, 0, 0, 0, 16'h0000, 16'h0000, 0, "dnpre2");
    cyc_b(1, 0, 0, 0, 16'h0000, 16'h9999, 1, "dnwrapB");
    cyc_b(1, 0, 0, 0, 16'h0000, 16'h9999, 0, "dnpre1b");
    cyc_b(0, 0, 0, 0, 16'h0000, 16'h9999, 0, "holdB");

    // Async reset mid-cycle, right after a wrap pulse on A
    cyc_a(0, 1, 0, 1, 0, 16'h9999, 16'h9999, 0, "load9999");
    cyc_a(1, 1, 0, 0, 0, 16'h0000, 16'h0000, 1, "upwrap2");
    @(negedge C);
    #3;
    R = 1'b1;
    #1;
    chk_reset("async");
    @(posedge C);
    if_a.EN = 1'b0; if_a.LOAD = 1'b0;
    @(posedge C);
    R = 1'b0;
    for (int i = 0; i < 5; i++) cyc_a(0, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, "postrst");

    // Let the monitor drain both queues
    @(posedge C);
    @(posedge C);
    chk("drain", 32'(q_a.size() + q_b.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
